// File: rtl/spi_xfer_ctrl.sv
// Two-requester SPI byte-exchange controller: round-robin grant, a 16-period SCK
// frame (8 bits out, then 8 bits in), and a held response.
module spi_xfer_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FALL_W = 4;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [FALL_W-1:0] fall_cnt;
  logic              last_half;
  logic [7:0]        tx;
  logic [7:0]        rx;
  logic              ptr;

  logic grant_id_c;
  logic half_done_c;

  // A lone requester wins outright; on contention the pointer decides.
  always_comb begin
    grant_id_c = ptr;
    if (req_valid == 2'b01) grant_id_c = 1'b0;
    else if (req_valid == 2'b10) grant_id_c = 1'b1;
  end

  assign half_done_c = (cnt == DIV_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      fall_cnt  <= '0;
      last_half <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      ptr       <= 1'b0;
      req_ready <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      sck       <= 1'b0;
      ss        <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // The grant cycle is spent in IDLE with req_ready high; SETUP follows it.
          if (req_ready != 2'b00) begin
            req_ready <= 2'b00;
            state     <= SETUP;
            ss        <= 1'b0;
            mosi      <= tx[0];
            cnt       <= '0;
          end else if (req_valid != 2'b00) begin
            req_ready <= grant_id_c ? 2'b10 : 2'b01;
            tx        <= grant_id_c ? req_data1 : req_data0;
            rsp_id    <= grant_id_c;
            ptr       <= ~grant_id_c;
          end
        end

        SETUP: begin
          if (half_done_c) begin
            cnt       <= '0;
            sck       <= 1'b1;
            fall_cnt  <= '0;
            last_half <= 1'b0;
            state     <= SHIFT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SHIFT: begin
          if (half_done_c) begin
            cnt <= '0;
            if (sck) begin
              // Falling edge j: advance mosi during the first byte, capture miso in the second.
              sck  <= 1'b0;
              mosi <= (fall_cnt < FALL_W'(7)) ? tx[3'(fall_cnt + FALL_W'(1))] : 1'b0;
              if (fall_cnt[3]) rx[fall_cnt[2:0]] <= miso;
              if (fall_cnt == FALL_W'(15)) last_half <= 1'b1;
              fall_cnt <= fall_cnt + FALL_W'(1);
            end else if (last_half) begin
              state <= HOLD;
            end else begin
              sck <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HOLD: begin
          if (half_done_c) begin
            cnt       <= '0;
            ss        <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= rx;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: a DIV=4 and a DIV=1 instance, each with a bit-reversing SPI slave.
module tb_spi_xfer_ctrl;

  localparam int unsigned DIV0 = 4;
  localparam int unsigned DIV1 = 1;

  logic       clock = 1'b0;
  logic       reset_n;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_data0, req_data1;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
  logic       sck, ss, mosi;
  logic       miso = 1'b0;

  logic [1:0] r1_valid;
  logic [1:0] r1_ready;
  logic [7:0] r1_data0, r1_data1;
  logic       r1_rsp_valid, r1_rsp_ready, r1_rsp_id;
  logic [7:0] r1_rsp_data;
  logic       sck1, ss1, mosi1;
  logic       miso1 = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_id;
    int         hold;
  } vec_t;

  typedef struct {
    logic       id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  spi_xfer_ctrl #(.DIV(DIV0)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  spi_xfer_ctrl #(.DIV(DIV1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(r1_valid), .req_ready(r1_ready),
    .req_data0(r1_data0), .req_data1(r1_data1),
    .rsp_valid(r1_rsp_valid), .rsp_ready(r1_rsp_ready),
    .rsp_id(r1_rsp_id), .rsp_data(r1_rsp_data),
    .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  // Slave: shift in 8 bits on rising SCK, then return them last-in-first-out.
  logic [7:0] s0_sr = 8'h00;
  int         s0_cnt = 0;
  always @(posedge sck or posedge ss) begin
    if (ss) s0_cnt = 0;
    else begin
      if (s0_cnt < 8) s0_sr = {s0_sr[6:0], mosi};
      else begin
        miso  = s0_sr[0];
        s0_sr = s0_sr >> 1;
      end
      s0_cnt++;
    end
  end

  logic [7:0] s1_sr = 8'h00;
  int         s1_cnt = 0;
  always @(posedge sck1 or posedge ss1) begin
    if (ss1) s1_cnt = 0;
    else begin
      if (s1_cnt < 8) s1_sr = {s1_sr[6:0], mosi1};
      else begin
        miso1 = s1_sr[0];
        s1_sr = s1_sr >> 1;
      end
      s1_cnt++;
    end
  end

  function automatic logic [7:0] bitrev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One full transaction on the DIV=4 instance, optionally stalling the response.
  task automatic run_vec(input vec_t v);
    int   c0;
    int   c1;
    exp_t e;
    @(negedge clock);
    req_valid = v.valid;
    req_data0 = v.d0;
    req_data1 = v.d1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready != 2'b00) break;
    end
    chk("grant", 32'(req_ready), v.exp_id ? 32'h2 : 32'h1);
    c0 = cycle;
    e.id   = v.exp_id;
    e.data = bitrev(v.exp_id ? v.d1 : v.d0);
    sb.push_back(e);
    req_valid = 2'b00;
    @(negedge clock);
    chk("ready_pulse", 32'(req_ready), 32'h0);
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid) break;
      @(negedge clock);
    end
    c1 = cycle;
    chk("latency", 32'(c1 - c0), 32'(34 * DIV0 + 1));
    chk("sb_depth", 32'(sb.size()), 32'h1);
    if (sb.size() > 0) e = sb.pop_front();
    chk("rsp_id", 32'(rsp_id), 32'(e.id));
    chk("rsp_data", 32'(rsp_data), 32'(e.data));
    chk("bus_idle", 32'({sck, ss}), 32'h1);
    if (v.hold > 0) begin
      req_valid = 2'b11;
      for (int i = 0; i < v.hold; i++) begin
        @(negedge clock);
        chk("hold_stable", 32'({rsp_valid, rsp_id, rsp_data, sck, ss, req_ready}),
            32'({1'b1, e.id, e.data, 1'b0, 1'b1, 2'b00}));
      end
      req_valid = 2'b00;
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("rsp_clear", 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int   falls;
    int   toggles;
    int   first_rise;
    int   last_tog;
    int   c0;
    int   c1;
    logic prev;
    logic seen;
    exp_t e;

    vecs[0] = '{2'b11, 8'h0F, 8'hF0, 1'b0, 0};
    vecs[1] = '{2'b11, 8'h0F, 8'hF0, 1'b1, 0};
    vecs[2] = '{2'b01, 8'h12, 8'h00, 1'b0, 10};
    vecs[3] = '{2'b01, 8'h5A, 8'h00, 1'b0, 0};
    vecs[4] = '{2'b10, 8'h00, 8'h01, 1'b1, 0};
    vecs[5] = '{2'b11, 8'hC3, 8'h81, 1'b0, 0};
    vecs[6] = '{2'b10, 8'h00, 8'hFF, 1'b1, 0};
    vecs[7] = '{2'b01, 8'h00, 8'h00, 1'b0, 0};

    reset_n      = 1'b0;
    req_valid    = 2'b00;
    req_data0    = 8'h00;
    req_data1    = 8'h00;
    rsp_ready    = 1'b0;
    r1_valid     = 2'b00;
    r1_data0     = 8'h00;
    r1_data1     = 8'h00;
    r1_rsp_ready = 1'b0;

    repeat (3) @(negedge clock);
    chk("reset_state", 32'({req_ready, rsp_valid, rsp_id, rsp_data, sck, ss, mosi}), 32'h2);
    chk("reset_state1", 32'({r1_ready, r1_rsp_valid, r1_rsp_id, r1_rsp_data, sck1, ss1, mosi1}), 32'h2);
    reset_n = 1'b1;

    foreach (vecs[k]) run_vec(vecs[k]);

    // Abort a transfer with reset right after falling edge 5.
    @(negedge clock);
    req_valid = 2'b01;
    req_data0 = 8'h12;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (req_ready != 2'b00) break;
    end
    req_valid = 2'b00;
    falls = 0;
    prev  = sck;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (prev && !sck) falls++;
      prev = sck;
      if (falls == 6) break;
    end
    chk("abort_reached_fall5", 32'(falls), 32'd6);
    reset_n = 1'b0;
    #1;
    chk("abort_ss_sck", 32'({ss, sck}), 32'h2);
    chk("abort_rsp", 32'(rsp_valid), 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_after_abort", 32'(seen), 32'h0);
    run_vec('{2'b10, 8'h00, 8'h3C, 1'b1, 0});

    // DIV=1: every SCK half-period is one clock.
    @(negedge clock);
    r1_valid = 2'b01;
    r1_data0 = 8'hA5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (r1_ready != 2'b00) break;
    end
    chk("d1_grant", 32'(r1_ready), 32'h1);
    c0 = cycle;
    e.id   = 1'b0;
    e.data = bitrev(8'hA5);
    sb.push_back(e);
    r1_valid   = 2'b00;
    toggles    = 0;
    first_rise = -1;
    last_tog   = -1;
    prev       = sck1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (sck1 != prev) begin
        toggles++;
        if (first_rise < 0) first_rise = cycle;
        last_tog = cycle;
      end
      prev = sck1;
      if (r1_rsp_valid) break;
    end
    c1 = cycle;
    chk("d1_toggles", 32'(toggles), 32'd32);
    chk("d1_span", 32'(last_tog - first_rise), 32'd31);
    chk("d1_latency", 32'(c1 - c0), 32'(34 * DIV1 + 1));
    chk("d1_sb_depth", 32'(sb.size()), 32'h1);
    if (sb.size() > 0) e = sb.pop_front();
    chk("d1_rsp_id", 32'(r1_rsp_id), 32'(e.id));
    chk("d1_rsp_data", 32'(r1_rsp_data), 32'(e.data));
    r1_rsp_ready = 1'b1;
    @(negedge clock);
    r1_rsp_ready = 1'b0;
    chk("d1_rsp_clear", 32'(r1_rsp_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
